// File: rtl/super_i3_bch_outer_enc_sched.sv
// Round-robin frame scheduler sharing one I.3 outer BCH encoder among pN_REQ streams.
// Each granted frame is 239 payload words followed by 3 zero flush words for the parity.
module super_i3_bch_outer_enc_sched #(
  parameter int pN_REQ = 4,
  parameter int pTAG_W = 3
) (
  input  logic                   iclk,
  input  logic                   ireset,
  input  logic                   iclkena,
  input  logic [pN_REQ-1:0]      ireq_val,
  input  logic [pN_REQ-1:0]      ireq_sop,
  input  logic [pN_REQ*16-1:0]   ireq_dat,
  output logic [pN_REQ-1:0]      oreq_rdy,
  output logic                   oenc_ival,
  output logic                   oenc_isop,
  output logic [15:0]            oenc_idat,
  output logic [pTAG_W-1:0]      otag,
  output logic                   obusy,
  output logic                   oerr
);

  typedef enum logic [1:0] {IDLE, DATA, FLUSH} state_t;

  localparam logic [pTAG_W:0] cN_REQ = (pTAG_W+1)'(pN_REQ);

  state_t              state, state_nxt;
  logic [pTAG_W-1:0]   grant, rr_ptr, winner, nxt_ptr;
  logic                found;
  logic [7:0]          wcnt;
  logic [1:0]          fcnt;
  logic [pN_REQ-1:0]   elig, rot;
  logic [2*pN_REQ-1:0] dbl;
  logic [pTAG_W:0]     sum, p1;
  logic                gval, gsop;
  logic [15:0]         gdat;

  assign elig  = ireq_val & ireq_sop;
  assign obusy = (state != IDLE);

  // rotate eligibility so that rr_ptr lands on bit 0, then take the lowest set bit
  always_comb begin
    dbl    = {elig, elig} >> rr_ptr;
    rot    = dbl[pN_REQ-1:0];
    found  = 1'b0;
    sum    = '0;
    for (int k = pN_REQ-1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, rr_ptr} + (pTAG_W+1)'(k);
      end
    end
    if (sum >= cN_REQ) sum = sum - cN_REQ;
    winner  = sum[pTAG_W-1:0];
    p1      = {1'b0, winner} + 1'b1;
    nxt_ptr = (p1 == cN_REQ) ? '0 : p1[pTAG_W-1:0];
  end

  always_comb begin
    gval = 1'b0;
    gsop = 1'b0;
    gdat = '0;
    for (int i = 0; i < pN_REQ; i++) begin
      if (grant == pTAG_W'(i)) begin
        gval = ireq_val[i];
        gsop = ireq_sop[i];
        gdat = ireq_dat[16*i +: 16];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    oreq_rdy  = '0;
    oenc_ival = 1'b0;
    oenc_isop = 1'b0;
    oenc_idat = '0;
    case (state)
      IDLE: begin
        if (iclkena) begin
          oreq_rdy = ireq_val & ~ireq_sop;
          if (found) state_nxt = DATA;
        end
      end
      DATA: begin
        oenc_idat = gdat;
        for (int i = 0; i < pN_REQ; i++)
          if (grant == pTAG_W'(i)) oreq_rdy[i] = iclkena;
        oenc_ival = gval & iclkena;
        oenc_isop = oenc_ival & (wcnt == 8'd0);
        if (oenc_ival && wcnt == 8'd238) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (iclkena) begin
          oenc_ival = 1'b1;
          if (fcnt == 2'd2) state_nxt = found ? DATA : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // otag follows every encoder input word so it lines up with the 1-cycle encoder output
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      wcnt   <= '0;
      fcnt   <= '0;
      otag   <= '0;
      oerr   <= 1'b0;
    end else if (iclkena) begin
      state <= state_nxt;
      oerr  <= 1'b0;
      case (state)
        IDLE: begin
          oerr <= |(ireq_val & ~ireq_sop);
          if (found) begin
            grant  <= winner;
            rr_ptr <= nxt_ptr;
            wcnt   <= '0;
          end
        end
        DATA: begin
          if (gval) begin
            otag <= grant;
            oerr <= gsop && (wcnt != 8'd0);
            wcnt <= (wcnt == 8'd238) ? 8'd0 : wcnt + 8'd1;
          end
        end
        FLUSH: begin
          otag <= grant;
          fcnt <= fcnt + 2'd1;
          if (fcnt == 2'd2) begin
            fcnt <= '0;
            if (found) begin
              grant  <= winner;
              rr_ptr <= nxt_ptr;
              wcnt   <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_super_i3_bch_outer_enc_sched.sv
// Randomised bench for the BCH encoder frame scheduler against a frame-level reference model.
module tb_super_i3_bch_outer_enc_sched;
  localparam int N  = 4;
  localparam int TW = 3;

  logic            iclk = 1'b0;
  logic            ireset, iclkena;
  logic [N-1:0]    ireq_val, ireq_sop, oreq_rdy;
  logic [N*16-1:0] ireq_dat;
  logic            oenc_ival, oenc_isop, obusy, oerr;
  logic [15:0]     oenc_idat;
  logic [TW-1:0]   otag;

  super_i3_bch_outer_enc_sched #(.pN_REQ(N), .pTAG_W(TW)) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
    .ireq_val(ireq_val), .ireq_sop(ireq_sop), .ireq_dat(ireq_dat),
    .oreq_rdy(oreq_rdy), .oenc_ival(oenc_ival), .oenc_isop(oenc_isop),
    .oenc_idat(oenc_idat), .otag(otag), .obusy(obusy), .oerr(oerr)
  );

  always #5 iclk = ~iclk;

  int n_vec = 0, n_err = 0, cyc = 0;
  // model: phase 0 idle, 1 taking payload, 2 flushing
  int m_phase, m_owner, m_next, m_cnt, m_flush, m_tag;
  bit m_err;
  // requester-side generators
  bit   in_frame[N];
  int   widx[N];
  int   frames_left[N];
  logic [15:0] cur_dat[N];
  bit   xfer[N];
  int   p_val, p_ena, p_garb, p_midsop, p_start;
  int   n_ival_seen, n_isop_seen;
  int   isop_cyc[$];
  int   isop_who[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelReset();
    m_phase = 0; m_owner = 0; m_next = 0; m_cnt = 0; m_flush = 0; m_tag = 0; m_err = 0;
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_next + k) % N;
      if (ireq_val[i] && ireq_sop[i]) return i;
    end
    return -1;
  endfunction

  task automatic startFrame(input int w);
    m_owner = w; m_next = (w + 1) % N; m_cnt = 0; m_phase = 1;
  endtask

  always @(negedge iclk) begin
    logic [N-1:0] e_rdy;
    logic         e_ival, e_isop;
    logic [15:0]  e_dat;
    int           w;
    cyc++;
    if (ireset) begin
      modelReset();
      for (int i = 0; i < N; i++) xfer[i] = 0;
      checkOutput("rst_rdy", 32'(oreq_rdy), 0);
      checkOutput("rst_ival", 32'(oenc_ival), 0);
      checkOutput("rst_isop", 32'(oenc_isop), 0);
      checkOutput("rst_idat", 32'(oenc_idat), 0);
      checkOutput("rst_tag", 32'(otag), 0);
      checkOutput("rst_busy", 32'(obusy), 0);
      checkOutput("rst_err", 32'(oerr), 0);
    end else begin
      e_rdy = '0; e_ival = 0; e_isop = 0; e_dat = '0;
      if (m_phase == 0 && iclkena) e_rdy = ireq_val & ~ireq_sop;
      if (m_phase == 1) begin
        e_dat = ireq_dat[16*m_owner +: 16];
        if (iclkena) begin
          e_rdy[m_owner] = 1'b1;
          e_ival = ireq_val[m_owner];
          e_isop = e_ival && (m_cnt == 0);
        end
      end
      if (m_phase == 2 && iclkena) e_ival = 1'b1;
      checkOutput("rdy", 32'(oreq_rdy), 32'(e_rdy));
      checkOutput("ival", 32'(oenc_ival), 32'(e_ival));
      checkOutput("isop", 32'(oenc_isop), 32'(e_isop));
      checkOutput("idat", 32'(oenc_idat), 32'(e_dat));
      checkOutput("tag", 32'(otag), 32'(m_tag));
      checkOutput("busy", 32'(obusy), 32'(m_phase != 0));
      checkOutput("err", 32'(oerr), 32'(m_err));
      for (int i = 0; i < N; i++) xfer[i] = e_rdy[i] & ireq_val[i];
      if (oenc_ival) n_ival_seen++;
      if (oenc_isop) begin
        n_isop_seen++;
        isop_cyc.push_back(cyc);
        w = -1;
        for (int i = 0; i < N; i++) if (oreq_rdy[i]) w = i;
        isop_who.push_back(w);
      end
      if (iclkena) begin
        case (m_phase)
          0: begin
            m_err = |(ireq_val & ~ireq_sop);
            w = pick();
            if (w >= 0) startFrame(w);
          end
          1: begin
            m_err = 0;
            if (ireq_val[m_owner]) begin
              m_tag = m_owner;
              m_err = ireq_sop[m_owner] && (m_cnt != 0);
              m_cnt++;
              if (m_cnt == 239) begin m_phase = 2; m_flush = 3; end
            end
          end
          default: begin
            m_err = 0;
            m_tag = m_owner;
            m_flush--;
            if (m_flush == 0) begin
              w = pick();
              if (w >= 0) startFrame(w); else m_phase = 0;
            end
          end
        endcase
      end
    end
  end

  task automatic clearDrivers();
    for (int i = 0; i < N; i++) begin
      in_frame[i] = 0; widx[i] = 0;
    end
    ireq_val = '0; ireq_sop = '0; ireq_dat = '0;
  endtask

  task automatic applyStimulus();
    iclkena = ($urandom_range(99) < p_ena);
    for (int i = 0; i < N; i++) begin
      logic v, s;
      if (xfer[i] && in_frame[i]) begin
        widx[i]++;
        cur_dat[i] = 16'($urandom);
        if (widx[i] == 239) begin in_frame[i] = 0; frames_left[i]--; end
      end
      if (!in_frame[i] && frames_left[i] > 0 && $urandom_range(99) < p_start) begin
        in_frame[i] = 1; widx[i] = 0; cur_dat[i] = 16'($urandom);
      end
      if (in_frame[i]) begin
        v = ($urandom_range(99) < p_val);
        s = (widx[i] == 0) || (widx[i] == 50 && $urandom_range(99) < p_midsop);
      end else begin
        v = ($urandom_range(99) < p_garb);
        s = 1'b0;
        cur_dat[i] = 16'($urandom);
      end
      ireq_val[i] = v;
      ireq_sop[i] = s;
      ireq_dat[16*i +: 16] = cur_dat[i];
    end
  endtask

  task automatic doReset(input int ncyc);
    @(posedge iclk); #1;
    ireset = 1'b1;
    clearDrivers();
    repeat (ncyc) @(posedge iclk);
    #1 ireset = 1'b0;
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(posedge iclk); #1;
      applyStimulus();
    end
  endtask

  initial begin
    ireset = 1'b1; iclkena = 1'b0;
    clearDrivers();
    for (int i = 0; i < N; i++) begin frames_left[i] = 0; xfer[i] = 0; cur_dat[i] = '0; end
    p_val = 100; p_ena = 100; p_garb = 0; p_midsop = 0; p_start = 100;
    repeat (3) @(posedge iclk);
    #1 ireset = 1'b0;

    // single frame from requester 1
    frames_left[1] = 1;
    n_ival_seen = 0; n_isop_seen = 0;
    isop_cyc.delete(); isop_who.delete();
    runCycles(300);
    checkOutput("A_ival_words", 32'(n_ival_seen), 242);
    checkOutput("A_isop_count", 32'(n_isop_seen), 1);
    checkOutput("A_tag", 32'(otag), 1);
    checkOutput("A_busy_end", 32'(obusy), 0);
    if (isop_who.size() > 0) checkOutput("A_owner", 32'(isop_who[0]), 1);

    // requesters 0 and 2 streaming back-to-back frames
    doReset(2);
    frames_left[0] = 2; frames_left[2] = 2;
    isop_cyc.delete(); isop_who.delete();
    runCycles(1100);
    checkOutput("B_frames", 32'(isop_who.size()), 4);
    for (int k = 0; k < 4 && k < isop_who.size(); k++)
      checkOutput("B_order", 32'(isop_who[k]), (k % 2 == 0) ? 0 : 2);
    for (int k = 1; k < 4 && k < isop_cyc.size(); k++)
      checkOutput("B_spacing", 32'(isop_cyc[k] - isop_cyc[k-1]), 242);

    // random traffic with stalls, clock-enable gaps, protocol errors and a mid-frame reset
    for (int i = 0; i < N; i++) frames_left[i] = 1000;
    p_val = 85; p_ena = 85; p_garb = 5; p_midsop = 30; p_start = 20;
    runCycles(3000);
    doReset(2);
    runCycles(3000);
    p_ena = 30;
    runCycles(800);
    p_ena = 100; p_garb = 0;
    runCycles(600);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
